// File: rtl/tcdm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_pkg
// Description : Shared TCDM protocol constants and the response record that
//               travels through the responder's latency pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
package tcdm_pkg;

  localparam int TCDM_ADDR_W = 32;
  localparam int TCDM_DATA_W = 32;
  localparam int TCDM_BE_W   = 4;

  // Read data returned for any access that misses the array window
  localparam logic [TCDM_DATA_W-1:0] TCDM_ERR_DATA = 32'hBADC_AB1E;

  typedef struct packed {
    logic                   valid;
    logic [TCDM_DATA_W-1:0] rdata;
    logic                   opc;
  } tcdm_resp_t;

endpackage : tcdm_pkg
`default_nettype wire

// File: rtl/tcdm_resp_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_resp_pipe
// Description : Fixed-depth shift register that delays a response record by
//               RESP_LATENCY cycles. Idle slots carry an all-zero record, so
//               the output is zero whenever valid is low.
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_resp_pipe
  import tcdm_pkg::*;
#(
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  tcdm_resp_t resp_i,
  output tcdm_resp_t resp_o
);

  tcdm_resp_t r_stage [RESP_LATENCY];

  // Shift responses one stage per cycle; reset drops everything in flight
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(RESP_LATENCY); i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= resp_i;
      for (int i = 1; i < int'(RESP_LATENCY); i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign resp_o = r_stage[RESP_LATENCY-1];

endmodule : tcdm_resp_pipe
`default_nettype wire

// File: rtl/tcdm_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tcdm_mem_responder
// Description : Single-port TCDM slave backed by a word-addressed array.
//               Grants after a programmable hold time, commits reads/writes
//               at the handshake edge and answers after a fixed latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tcdm_mem_responder
  import tcdm_pkg::*;
#(
  parameter int unsigned             MEM_WORDS    = 1024,
  parameter logic [TCDM_ADDR_W-1:0]  BASE_ADDR    = 32'h1C00_0000,
  parameter int unsigned             GNT_DELAY    = 0,
  parameter int unsigned             RESP_LATENCY = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   req_i,
  input  logic [TCDM_ADDR_W-1:0] add_i,
  input  logic                   wen_i,
  input  logic [TCDM_DATA_W-1:0] wdata_i,
  input  logic [TCDM_BE_W-1:0]   be_i,
  output logic                   gnt_o,
  output logic                   r_valid_o,
  output logic [TCDM_DATA_W-1:0] r_rdata_o,
  output logic                   r_opc_o
);

  localparam int unsigned            c_IDX_W     = $clog2(MEM_WORDS);
  localparam logic [TCDM_ADDR_W-1:0] c_MEM_BYTES = TCDM_ADDR_W'(MEM_WORDS * 4);
  localparam logic [3:0]             c_GNT_DELAY = 4'(GNT_DELAY);

  logic [3:0]             r_wait_cnt;
  logic                   w_gnt;
  logic [TCDM_ADDR_W-1:0] w_offset;
  logic                   w_in_range;
  logic [c_IDX_W-1:0]     w_idx;
  logic [TCDM_DATA_W-1:0] r_mem [MEM_WORDS];
  tcdm_resp_t             w_resp_in;
  tcdm_resp_t             w_resp_out;

  // Grant once the request has been held GNT_DELAY cycles; never while in
  // reset, so a request present during reset cannot touch the array.
  assign w_gnt = req_i & rst_ni & (r_wait_cnt == c_GNT_DELAY);
  assign gnt_o = w_gnt;

  // Unsigned wrap makes addresses below the base land far out of range
  assign w_offset   = add_i - BASE_ADDR;
  assign w_in_range = (w_offset < c_MEM_BYTES);
  assign w_idx      = w_offset[c_IDX_W+1:2];

  // Hold-time counter: runs while a request waits, restarts on grant or drop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wait_cnt <= 4'd0;
    end else if (!req_i || w_gnt) begin
      r_wait_cnt <= 4'd0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end

  // Byte-masked write commit at the handshake edge; out-of-range writes drop
  always_ff @(posedge clk_i) begin
    if (w_gnt && !wen_i && w_in_range) begin
      for (int n = 0; n < TCDM_BE_W; n++) begin
        if (be_i[n]) begin
          r_mem[w_idx][8*n +: 8] <= wdata_i[8*n +: 8];
        end
      end
    end
  end

  // Build the response record; the pipe's first stage captures it at the
  // handshake edge, which is where the read value is sampled.
  always_comb begin
    w_resp_in = '0;
    if (w_gnt) begin
      w_resp_in.valid = 1'b1;
      if (!w_in_range) begin
        w_resp_in.rdata = TCDM_ERR_DATA;
        w_resp_in.opc   = 1'b1;
      end else if (wen_i) begin
        w_resp_in.rdata = r_mem[w_idx];
      end
    end
  end

  tcdm_resp_pipe #(
    .RESP_LATENCY (RESP_LATENCY)
  ) u_resp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .resp_i (w_resp_in),
    .resp_o (w_resp_out)
  );

  assign r_valid_o = w_resp_out.valid;
  assign r_rdata_o = w_resp_out.rdata;
  assign r_opc_o   = w_resp_out.opc;

endmodule : tcdm_mem_responder
`default_nettype wire

// File: tb/tb_tcdm_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_tcdm_mem_responder
// Description : Three responder instances with different grant/latency
//               settings, driven by directed then random traffic and compared
//               against a transaction-level memory/response model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tcdm_mem_responder;

  localparam logic [31:0] BASE  = 32'h1C00_0000;
  localparam int          WORDS = 1024;
  localparam int          NI    = 3;
  localparam int          GD_A  [NI] = '{0, 3, 0};
  localparam int          LAT_A [NI] = '{1, 3, 4};

  typedef struct {
    bit          idle;
    bit          rd;
    logic [31:0] add;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          drop_after;
  } cmd_t;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        opc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req    [NI];
  logic [31:0] add    [NI];
  logic        wen    [NI];
  logic [31:0] wdata  [NI];
  logic [3:0]  be     [NI];
  logic        gnt    [NI];
  logic        rvalid [NI];
  logic [31:0] rdata  [NI];
  logic        opc    [NI];

  cmd_t        cq [NI][$];
  exp_t        eq [NI][$];
  logic [31:0] mm [NI][WORDS];
  int          mcnt [NI];
  bit          active [NI];
  bit          last_eg [NI];
  int          held [NI];
  int          drop_lim [NI];
  int          cyc;
  int          n_checks;
  int          n_fail;
  bit          rand_mode;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    tcdm_mem_responder #(
      .MEM_WORDS    (WORDS),
      .BASE_ADDR    (BASE),
      .GNT_DELAY    (GD_A[g]),
      .RESP_LATENCY (LAT_A[g])
    ) u_dut (
      .clk_i     (clk),
      .rst_ni    (rst_n),
      .req_i     (req[g]),
      .add_i     (add[g]),
      .wen_i     (wen[g]),
      .wdata_i   (wdata[g]),
      .be_i      (be[g]),
      .gnt_o     (gnt[g]),
      .r_valid_o (rvalid[g]),
      .r_rdata_o (rdata[g]),
      .r_opc_o   (opc[g])
    );
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  function automatic cmd_t mk(bit rd, logic [31:0] a, logic [31:0] d, logic [3:0] b, int drop);
    cmd_t c;
    c.idle = 1'b0; c.rd = rd; c.add = a; c.wdata = d; c.be = b; c.drop_after = drop;
    return c;
  endfunction

  function automatic cmd_t mk_idle();
    cmd_t c;
    c = mk(1'b1, 32'h0, 32'h0, 4'h0, 0);
    c.idle = 1'b1;
    return c;
  endfunction

  function automatic cmd_t rand_cmd(int i);
    cmd_t c;
    int   r;
    c.idle  = ($urandom_range(0, 3) == 0);
    c.rd    = 1'($urandom_range(0, 1));
    r       = int'($urandom_range(0, 19));
    if (r < 17)       c.add = BASE + ($urandom_range(0, 15) << 2) + $urandom_range(0, 3);
    else if (r == 17) c.add = BASE + 32'(WORDS * 4) + ($urandom_range(0, 255) << 2);
    else if (r == 18) c.add = BASE - 4 * $urandom_range(1, 64);
    else              c.add = $urandom;
    c.wdata      = $urandom;
    c.be         = 4'($urandom_range(0, 15));
    c.drop_after = 0;
    if (GD_A[i] > 1 && $urandom_range(0, 9) == 0)
      c.drop_after = int'($urandom_range(1, GD_A[i] - 1));
    return c;
  endfunction

  task automatic check_resp(int i);
    exp_t e;
    if (eq[i].size() > 0 && eq[i][0].due == cyc) begin
      e = eq[i].pop_front();
      check_val($sformatf("r_valid[%0d]", i), rvalid[i], 1);
      check_val($sformatf("r_rdata[%0d]", i), rdata[i], e.rdata);
      check_val($sformatf("r_opc[%0d]", i), opc[i], e.opc);
    end else begin
      check_val($sformatf("r_valid_idle[%0d]", i), rvalid[i], 0);
      check_val($sformatf("r_rdata_idle[%0d]", i), rdata[i], 0);
      check_val($sformatf("r_opc_idle[%0d]", i), opc[i], 0);
    end
  endtask

  task automatic drive(int i);
    cmd_t c;
    if (active[i] && !last_eg[i]) begin
      held[i]++;
      if (drop_lim[i] > 0 && held[i] >= drop_lim[i]) begin
        req[i]    = 1'b0;
        active[i] = 1'b0;
      end
    end else begin
      active[i] = 1'b0;
      req[i]    = 1'b0;
      if (cq[i].size() > 0) c = cq[i].pop_front();
      else if (rand_mode)   c = rand_cmd(i);
      else                  c = mk_idle();
      if (!c.idle) begin
        req[i]      = 1'b1;
        add[i]      = c.add;
        wen[i]      = c.rd;
        wdata[i]    = c.wdata;
        be[i]       = c.be;
        held[i]     = 0;
        drop_lim[i] = c.drop_after;
        active[i]   = 1'b1;
      end else begin
        add[i]   = $urandom;
        wen[i]   = 1'($urandom_range(0, 1));
        wdata[i] = $urandom;
        be[i]    = 4'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic grant_model(int i);
    bit          eg;
    bit          inr;
    logic [31:0] off;
    int          idx;
    exp_t        e;
    eg = req[i] && (mcnt[i] == GD_A[i]);
    check_val($sformatf("gnt[%0d]", i), gnt[i], eg);
    if (eg) begin
      off   = add[i] - BASE;
      inr   = (off < 32'(WORDS * 4));
      idx   = int'(off >> 2);
      e.due = cyc + LAT_A[i];
      e.opc = 1'b0;
      if (!inr) begin
        e.rdata = 32'hBADC_AB1E;
        e.opc   = 1'b1;
      end else if (wen[i]) begin
        e.rdata = mm[i][idx];
      end else begin
        for (int n = 0; n < 4; n++)
          if (be[i][n]) mm[i][idx][8*n +: 8] = wdata[i][8*n +: 8];
        e.rdata = 32'h0;
      end
      eq[i].push_back(e);
    end
    if (!req[i] || eg) mcnt[i] = 0;
    else               mcnt[i]++;
    last_eg[i] = eg;
  endtask

  task automatic run_cycle();
    @(negedge clk);
    for (int i = 0; i < NI; i++) check_resp(i);
    for (int i = 0; i < NI; i++) drive(i);
    #1;
    for (int i = 0; i < NI; i++) grant_model(i);
    cyc++;
  endtask

  task automatic check_all_zero(string tag);
    for (int i = 0; i < NI; i++) begin
      check_val($sformatf("%s_gnt[%0d]", tag, i), gnt[i], 0);
      check_val($sformatf("%s_valid[%0d]", tag, i), rvalid[i], 0);
      check_val($sformatf("%s_rdata[%0d]", tag, i), rdata[i], 0);
      check_val($sformatf("%s_opc[%0d]", tag, i), opc[i], 0);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; active[i] = 1'b0; last_eg[i] = 1'b0; mcnt[i] = 0;
      eq[i].delete();
    end
    // A write presented during reset must be neither granted nor committed
    req[0] = 1'b1; wen[0] = 1'b0; add[0] = BASE; wdata[0] = $urandom; be[0] = 4'hF;
    #1;
    check_all_zero("rst_now");
    repeat (2) @(negedge clk);
    check_all_zero("rst_hold");
    req[0] = 1'b0;
    rst_n  = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    n_checks = 0; n_fail = 0; cyc = 0; rand_mode = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < NI; i++) begin
      req[i] = 1'b0; add[i] = '0; wen[i] = 1'b1; wdata[i] = '0; be[i] = '0;
      mcnt[i] = 0; active[i] = 1'b0; last_eg[i] = 1'b0; held[i] = 0; drop_lim[i] = 0;
      // Preload a 16-word window so every later read has a known value
      for (int w = 0; w < 16; w++) cq[i].push_back(mk(1'b0, BASE + 32'(w * 4), $urandom, 4'hF, 0));
      cq[i].push_back(mk_idle());
    end

    // Write then immediate read, partial byte-enable merge, out-of-range cases
    cq[0].push_back(mk(1'b0, BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0));
    cq[0].push_back(mk(1'b1, BASE + 32'h10, 32'h0, 4'h0, 0));
    cq[0].push_back(mk(1'b0, BASE + 32'h10, 32'h1122_3344, 4'b0101, 0));
    cq[0].push_back(mk(1'b1, BASE + 32'h10, 32'h0, 4'h0, 0));
    cq[0].push_back(mk(1'b0, BASE + 32'h14, 32'h5555_AAAA, 4'h0, 0));
    cq[0].push_back(mk(1'b1, BASE + 32'h14, 32'h0, 4'h0, 0));
    cq[0].push_back(mk(1'b1, BASE + 32'h1000, 32'h0, 4'h0, 0));
    cq[0].push_back(mk(1'b1, BASE - 32'h4, 32'h0, 4'h0, 0));
    cq[0].push_back(mk(1'b0, BASE + 32'h1000, 32'hFFFF_FFFF, 4'hF, 0));
    cq[0].push_back(mk(1'b1, BASE, 32'h0, 4'h0, 0));

    // Abandoned request after two held cycles, then reassert and wait again
    cq[1].push_back(mk(1'b1, BASE + 32'h14, 32'h0, 4'h0, 2));
    cq[1].push_back(mk(1'b1, BASE + 32'h14, 32'h0, 4'h0, 0));
    cq[1].push_back(mk(1'b1, BASE + 32'h18, 32'h0, 4'h0, 0));

    // Back-to-back reads with no grant delay: responses in consecutive cycles
    for (int w = 0; w < 4; w++) cq[2].push_back(mk(1'b1, BASE + 32'(w * 4), 32'h0, 4'h0, 0));

    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    guard = 0;
    while ((cq[0].size() + cq[1].size() + cq[2].size()) > 0 && guard < 2000) begin
      run_cycle();
      guard++;
    end
    repeat (8) run_cycle();

    rand_mode = 1'b1;
    repeat (800) run_cycle();

    guard = 0;
    while ((eq[1].size() + eq[2].size()) < 2 && guard < 200) begin
      run_cycle();
      guard++;
    end
    pulse_reset();

    repeat (600) run_cycle();
    rand_mode = 1'b0;
    repeat (12) run_cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tcdm_mem_responder
`default_nettype wire
